// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: self-issuing sequential IM fetcher feeding ID through a DEPTH-entry {pc,instr} FIFO; jump redirects flush it; define MISALIGN_TRAP_EN for a sticky fetch_misaligned output on unaligned redirects
module inst_prefetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         instr_read,
`ifdef MISALIGN_TRAP_EN
  output logic                         fetch_misaligned,
`endif
  output logic [ADDR_WIDTH-1:0]        instr_addr,
  input  logic [INST_WIDTH-1:0]        instr_out,
  input  logic                         jump_flag_id,
  input  logic [ADDR_WIDTH-1:0]        jump_address_id,
  output logic                         instruction_valid,
  output logic [INST_WIDTH-1:0]        instruction,
  output logic [ADDR_WIDTH-1:0]        instruction_address,
  input  logic                         instruction_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, r_pending_addr;
  logic                  r_pending;
  logic [PW-1:0]         r_rd, r_wr;
  logic [ADDR_WIDTH-1:0] r_addr_q [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_q [DEPTH];
  logic                  w_pop, w_block;
  logic [PW:0]           w_credit;
  logic [ADDR_WIDTH-1:0] w_target;
`ifdef MISALIGN_TRAP_EN
  logic r_misaligned;
  assign fetch_misaligned = r_misaligned;
  assign w_block = r_misaligned;
  assign w_target = jump_address_id;
`else
  assign w_block = 1'b0;
  assign w_target = jump_address_id & ~ADDR_WIDTH'(3);
`endif
  assign fill_level = r_wr - r_rd;
  assign w_credit = {1'b0, fill_level} + {{PW{1'b0}}, r_pending};
  assign instr_read = !rst && !jump_flag_id && !w_block && (w_credit < (PW+1)'(DEPTH));
  assign instr_addr = r_fetch_pc;
  assign instruction_valid = r_wr != r_rd;
  assign instruction = r_inst_q[r_rd[IW-1:0]];
  assign instruction_address = r_addr_q[r_rd[IW-1:0]];
  assign w_pop = instruction_valid && instruction_ready && !jump_flag_id;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pending <= 1'b0;
      r_pending_addr <= RESET_PC;
      r_rd <= '0;
      r_wr <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misaligned <= 1'b0;
`endif
    end else if (jump_flag_id) begin
      r_fetch_pc <= w_target;
      r_pending <= 1'b0;
      r_rd <= r_wr;
`ifdef MISALIGN_TRAP_EN
      r_misaligned <= |jump_address_id[1:0];
`endif
    end else begin
      r_pending <= instr_read;
      if (instr_read) begin
        r_pending_addr <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      end
      if (r_pending) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !jump_flag_id && r_pending) begin
      r_addr_q[r_wr[IW-1:0]] <= r_pending_addr;
      r_inst_q[r_wr[IW-1:0]] <= instr_out;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: vector table, directed corner sequences and random traffic against a queue-level model of the prefetcher
module tb_inst_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic [31:0] instr_out = 32'hDEADBEEF;
  logic        jump_flag_id = 1'b0;
  logic [31:0] jump_address_id = '0;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_address;
  logic        instruction_ready = 1'b0;
  logic [2:0]  fill_level;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;
  ent_t mq[$];
  logic        m_pend = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_fpc = '0;
  logic        s_read, s_valid;
  logic [31:0] s_iaddr, s_haddr, s_inst;
  logic [2:0]  s_fill;
  typedef struct {
    logic        r;
    logic        j;
    logic [31:0] ja;
    logic        rdy;
    logic        e_read;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_haddr;
    logic [2:0]  e_fill;
  } vec_t;
  vec_t vt[11];
  inst_prefetch_queue dut (
    .clk(clk),
    .rst(rst),
    .instr_read(instr_read),
    .instr_addr(instr_addr),
    .instr_out(instr_out),
    .jump_flag_id(jump_flag_id),
    .jump_address_id(jump_address_id),
    .instruction_valid(instruction_valid),
    .instruction(instruction),
    .instruction_address(instruction_address),
    .instruction_ready(instruction_ready),
    .fill_level(fill_level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) instr_out <= instr_read ? instr_addr + 32'h100 : 32'hDEADBEEF;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic rdy);
    bit iss;
    rst = r;
    jump_flag_id = j;
    jump_address_id = ja;
    instruction_ready = rdy;
    #1;
    s_read = instr_read;
    s_iaddr = instr_addr;
    s_valid = instruction_valid;
    s_haddr = instruction_address;
    s_inst = instruction;
    s_fill = fill_level;
    chk("model_read", 32'(s_read), 32'(!r && !j && (mq.size() + int'(m_pend) < 4)));
    if (!r) begin
      chk("model_iaddr", s_iaddr, m_fpc);
      chk("model_valid", 32'(s_valid), 32'(mq.size() != 0));
      chk("model_fill", 32'(s_fill), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("model_head_addr", s_haddr, mq[0].a);
        chk("model_head_inst", s_inst, mq[0].i);
      end
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc = 32'h0;
    end else if (j) begin
      mq.delete();
      m_pend = 1'b0;
      m_fpc = ja & ~32'h3;
    end else begin
      iss = (mq.size() + int'(m_pend)) < 4;
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_pend) mq.push_back('{m_paddr, m_paddr + 32'h100});
      m_pend = iss;
      if (iss) begin
        m_paddr = m_fpc;
        m_fpc = m_fpc + 32'h4;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int pops;
    vt[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   3'd0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   3'd0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   3'd0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0,   3'd1};
    vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4,   3'd1};
    vt[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h8,   3'd1};
    vt[6]  = '{1'b0, 1'b1, 32'h202, 1'b1, 1'b0, 32'h14,  1'b1, 32'hC,   3'd1};
    vt[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   3'd0};
    vt[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   3'd0};
    vt[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200, 3'd1};
    vt[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b1, 32'h204, 3'd1};
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      step(vt[k].r, vt[k].j, vt[k].ja, vt[k].rdy);
      chk($sformatf("vec%0d_read", k), 32'(s_read), 32'(vt[k].e_read));
      chk($sformatf("vec%0d_iaddr", k), s_iaddr, vt[k].e_iaddr);
      chk($sformatf("vec%0d_valid", k), 32'(s_valid), 32'(vt[k].e_valid));
      chk($sformatf("vec%0d_fill", k), 32'(s_fill), 32'(vt[k].e_fill));
      if (vt[k].e_valid) begin
        chk($sformatf("vec%0d_haddr", k), s_haddr, vt[k].e_haddr);
        chk($sformatf("vec%0d_inst", k), s_inst, vt[k].e_haddr + 32'h100);
      end
    end
    step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("bp_fill_sat", 32'(s_fill), 32'd4);
    chk("bp_read_low", 32'(s_read), 32'd0);
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1);
      chk("bp_drain_valid", 32'(s_valid), 32'd1);
      if (s_valid) begin
        chk("bp_drain_order", s_haddr, 32'(pops * 4));
        pops++;
      end
    end
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    step(0, 1, 32'h200, 0);
    chk("rd_pre_fill", 32'(s_fill), 32'd3);
    step(0, 0, 0, 1);
    chk("rd_flush_fill", 32'(s_fill), 32'd0);
    chk("rd_flush_valid", 32'(s_valid), 32'd0);
    chk("rd_new_addr", s_iaddr, 32'h200);
    chk("rd_new_read", 32'(s_read), 32'd1);
    step(0, 0, 0, 1);
    chk("rd_n2_valid", 32'(s_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("rd_n3_valid", 32'(s_valid), 32'd1);
    chk("rd_n3_addr", s_haddr, 32'h200);
    step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    step(0, 1, 32'h300, 1);
    chk("jp_full_fill", 32'(s_fill), 32'd4);
    chk("jp_full_head", s_haddr, 32'h0);
    step(0, 0, 0, 1);
    chk("jp_n1_valid", 32'(s_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("jp_n2_valid", 32'(s_valid), 32'd0);
    step(0, 0, 0, 1);
    chk("jp_n3_addr", s_haddr, 32'h300);
    step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rs_no_push_fill", 32'(s_fill), 32'd0);
    chk("rs_restart_addr", s_iaddr, 32'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rs_first_valid", 32'(s_valid), 32'd1);
    chk("rs_first_addr", s_haddr, 32'h0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
           32'($urandom_range(0, 1023)), $urandom_range(0, 2) != 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Parametrised successor to the single-cycle instruction-fetch stage.
- Decouples instruction-memory fetch from decode with a DEPTH-entry prefetch FIFO of {address, instruction} pairs.
- Issues sequential fetches on its own, flushes on a jump redirect from EXE, and presents a valid/ready stream to ID.
- Sits between the IM port (instr_read/instr_addr/instr_out) and the ID/EXE stages of the CPU top.

Parameters:
ADDR_WIDTH, 32, width of PC / instr_addr / jump address
INST_WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_read  out  1  IM read enable
instr_addr  out  ADDR_WIDTH  IM read address (= fetch_pc)
instr_out  in  INST_WIDTH  IM read data, valid exactly 1 cycle after instr_read=1
jump_flag_id  in  1  redirect request from EXE (single-cycle pulse or level)
jump_address_id  in  ADDR_WIDTH  redirect target
instruction_valid  out  1  FIFO head valid (not empty)
instruction  out  INST_WIDTH  FIFO head instruction
instruction_address  out  ADDR_WIDTH  FIFO head PC
instruction_ready  in  1  ID accepts head this cycle
fill_level  out  $clog2(DEPTH+1)  current occupied entries

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, FIFO empty, pending=0, fill_level=0, instruction_valid=0. instr_read=0 while rst=1. A response arriving the cycle after reset is discarded.
- State: fetch_pc, pending (1-bit in-flight flag), pending_addr, FIFO rd/wr pointers with extra wrap bit.
- Issue: instr_read=1 when !rst && !jump_flag_id && (fill_level + pending) < DEPTH. On issue: pending<=1, pending_addr<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^ADDR_WIDTH, wrap silently). Otherwise pending<=0.
- Capture: if pending=1 and no redirect this cycle, push {pending_addr, instr_out} at the edge.
- Pop: instruction_valid && instruction_ready && !jump_flag_id pops the head at the edge. Push and pop in the same cycle are both performed, fill_level unchanged. When full, the credit rule guarantees no push.
- instruction / instruction_address are registered FIFO head outputs, don't-care when instruction_valid=0. instruction_ready while empty has no effect.
- Redirect (jump_flag_id=1 at edge):
  - FIFO flushed; pending cleared, so the in-flight response is dropped.
  - fetch_pc<=jump_address_id.
  - No issue and no pop that cycle; redirect wins over push and pop.
- Latency:
  - Request issued in cycle N → entry visible (instruction_valid=1) in cycle N+2.
  - First fetch issued in the first cycle with rst=0, so first instruction is valid 2 cycles after reset release.
  - Redirect in cycle N → new-target request in N+1 → target valid in N+3.
- Steady state with instruction_ready held at 1: one instruction per cycle, no bubbles.
- Back-to-back redirects: each one flushes; only the last target survives.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with jump_address_id[1:0] != 0 sets fetch_misaligned=1 (sticky), flushes, and suppresses all issue.
  - The flag clears and fetching resumes on the next redirect to an aligned address, or on rst.
- Not defined:
  - No extra port.
  - jump_address_id[1:0] is forced to 2'b00 on load into fetch_pc.

Test Plan:
- Reset release with RESET_PC=0, IM returning mem[a]=a+0x100, instruction_ready=1 → instruction_valid first high 2 cycles after release; stream addrs 0,4,8,... with instr 0x100,0x104,... one per cycle.
- instruction_ready=0 for 10 cycles → fill_level saturates at DEPTH=4; instr_read low once fill_level+pending=4; on release, addrs pop in order with no gaps or duplicates.
- Redirect pulse to 0x200 while FIFO holds 3 entries and a request is pending → next cycle fill_level=0 and instruction_valid=0; instr_addr=0x200 with instr_read=1; 0x200 is valid 3 cycles after the pulse; no stale address is ever presented.
- jump_flag_id and a pop (instruction_ready=1) in the same cycle, with a full FIFO → flush only; 0x300 is the next address delivered.
- rst asserted mid-stream with pending=1 → the response in the following cycle is not pushed; after release, addrs restart at RESET_PC.
- MISALIGN_TRAP_EN: redirect to 0x202 → fetch_misaligned=1 and instr_read stays 0; a later redirect to 0x400 clears the flag and fetches 0x400. Without the macro: redirect to 0x202 fetches 0x200.
